// File: rtl/a2d_sched.sv
// Round-robin scheduler sharing one SPI A2D among four analog sources (ch 0, 4, 5, 6).
// Define A2D_SCHED_LD_AVG_EN to make lft_ld/rght_ld two-sample running averages.
module a2d_sched #(
  parameter bit          FAST_SIM = 1'b1,
  parameter int unsigned TMO_CYC  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        err_clr,
  input  logic        a2d_done,
  input  logic [11:0] a2d_data,
  output logic        a2d_strt,
  output logic [2:0]  a2d_chnl,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        smpl_vld,
  output logic        a2d_err
);

  localparam int unsigned TW = FAST_SIM ? 8 : 16;
  localparam int unsigned CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [CW-1:0] TmoLast = CW'(TMO_CYC - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StNext} state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [1:0]    slot_q;
  logic [CW-1:0] tmo_q;
  logic          tick;
  logic [11:0]   lft_new;
  logic [11:0]   rght_new;

  assign tick = &timer_q;

  function automatic logic [2:0] slot_chnl(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd0;
      2'd1:    return 3'd4;
      2'd2:    return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

`ifdef A2D_SCHED_LD_AVG_EN
  logic        lft_seen_q;
  logic        rght_seen_q;
  logic        lft_we;
  logic        rght_we;
  logic [12:0] lft_sum;
  logic [12:0] rght_sum;

  assign lft_we   = (state_q == StWait) && a2d_done && (slot_q == 2'd0);
  assign rght_we  = (state_q == StWait) && a2d_done && (slot_q == 2'd1);
  assign lft_sum  = {1'b0, lft_ld} + {1'b0, a2d_data};
  assign rght_sum = {1'b0, rght_ld} + {1'b0, a2d_data};
  // First sample after reset loads raw so the average does not start from 0.
  assign lft_new  = lft_seen_q ? lft_sum[12:1] : a2d_data;
  assign rght_new = rght_seen_q ? rght_sum[12:1] : a2d_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      lft_seen_q  <= 1'b0;
      rght_seen_q <= 1'b0;
    end else begin
      if (lft_we)  lft_seen_q  <= 1'b1;
      if (rght_we) rght_seen_q <= 1'b1;
    end
  end
`else
  assign lft_new  = a2d_data;
  assign rght_new = a2d_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      slot_q    <= 2'd0;
      tmo_q     <= '0;
      a2d_strt  <= 1'b0;
      a2d_chnl  <= 3'd0;
      lft_ld    <= 12'd0;
      rght_ld   <= 12'd0;
      steer_pot <= 12'd0;
      batt      <= 12'd0;
      smpl_vld  <= 1'b0;
      a2d_err   <= 1'b0;
    end else begin
      timer_q  <= timer_q + 1'b1;
      a2d_strt <= 1'b0;
      smpl_vld <= 1'b0;
      // A timeout later in this block overrides the clear.
      if (err_clr) a2d_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tick && en) begin
            slot_q   <= 2'd0;
            a2d_strt <= 1'b1;
            a2d_chnl <= slot_chnl(2'd0);
            state_q  <= StStart;
          end
        end
        StStart: begin
          tmo_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (a2d_done) begin
            case (slot_q)
              2'd0:    lft_ld    <= lft_new;
              2'd1:    rght_ld   <= rght_new;
              2'd2:    steer_pot <= a2d_data;
              default: batt      <= a2d_data;
            endcase
            state_q <= StNext;
          end else if (tmo_q == TmoLast) begin
            a2d_err <= 1'b1;
            state_q <= StNext;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StNext: begin
          if ((slot_q == 2'd3) || !en) begin
            smpl_vld <= (slot_q == 2'd3);
            slot_q   <= 2'd0;
            state_q  <= StIdle;
          end else begin
            slot_q   <= slot_q + 2'd1;
            a2d_strt <= 1'b1;
            a2d_chnl <= slot_chnl(slot_q + 2'd1);
            state_q  <= StStart;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_sched.sv
// Directed self-checking bench for a2d_sched with a scripted A2D responder.
module tb_a2d_sched;

  logic        clk;
  logic        rst;
  logic        en;
  logic        err_clr;
  logic        a2d_done;
  logic [11:0] a2d_data;
  logic        a2d_strt;
  logic [2:0]  a2d_chnl;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic        smpl_vld;
  logic        a2d_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int strt_cnt = 0;
  int vld_cnt  = 0;

`ifdef A2D_SCHED_LD_AVG_EN
  localparam logic [11:0] L2 = 12'h11A, R2 = 12'h33C, L3 = 12'h0E2, R3 = 12'h1FB;
  localparam logic [11:0] L4 = 12'h0DF, R4 = 12'h3A8, L7 = 12'h180;
`else
  localparam logic [11:0] L2 = 12'h111, R2 = 12'h222, L3 = 12'h0AA, R3 = 12'h0BB;
  localparam logic [11:0] L4 = 12'h0DD, R4 = 12'h555, L7 = 12'h200;
`endif

  a2d_sched #(
    .FAST_SIM (1'b1),
    .TMO_CYC  (1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .err_clr   (err_clr),
    .a2d_done  (a2d_done),
    .a2d_data  (a2d_data),
    .a2d_strt  (a2d_strt),
    .a2d_chnl  (a2d_chnl),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .smpl_vld  (smpl_vld),
    .a2d_err   (a2d_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a2d_strt) strt_cnt <= strt_cnt + 1;
    if (smpl_vld) vld_cnt <= vld_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_strt(input int budget, output logic [2:0] ch, output int t);
    logic seen;
    seen = 1'b0;
    ch   = 3'd0;
    t    = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (a2d_strt) begin
        seen = 1'b1;
        ch   = a2d_chnl;
        t    = cyc;
      end
    end
    check("strt_seen", 32'(seen), 32'd1);
  endtask

  task automatic respond(input int dly, input logic [11:0] d);
    repeat (dly) @(posedge clk);
    #1;
    a2d_done = 1'b1;
    a2d_data = d;
    @(posedge clk);
    #1;
    a2d_done = 1'b0;
    a2d_data = 12'd0;
  endtask

  task automatic run_slot(input string tag, input logic [2:0] exp_ch, input logic [11:0] d,
                          output int t);
    logic [2:0] ch;
    wait_strt(600, ch, t);
    check(tag, 32'(ch), 32'(exp_ch));
    respond(2, d);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_lft"}, 32'(lft_ld), 32'd0);
    check({tag, "_rght"}, 32'(rght_ld), 32'd0);
    check({tag, "_steer"}, 32'(steer_pot), 32'd0);
    check({tag, "_batt"}, 32'(batt), 32'd0);
    check({tag, "_strt"}, 32'(a2d_strt), 32'd0);
    check({tag, "_chnl"}, 32'(a2d_chnl), 32'd0);
    check({tag, "_vld"}, 32'(smpl_vld), 32'd0);
    check({tag, "_err"}, 32'(a2d_err), 32'd0);
  endtask

  initial begin
    int         t;
    int         t_first;
    int         t_rel;
    int         ts;
    int         n_err;
    int         v0;
    int         s0;
    logic       seen_err;
    logic [2:0] ch;

    rst      = 1'b1;
    en       = 1'b0;
    err_clr  = 1'b0;
    a2d_done = 1'b0;
    a2d_data = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    en    = 1'b1;
    t_rel = cyc;
    @(negedge clk);
    check_zero("reset");

    // Round 1: basic sequencing and first-strt latency after the first tick.
    v0 = vld_cnt;
    run_slot("r1_ch0", 3'd0, 12'h123, t_first);
    check("r1_first_strt", 32'(t_first - t_rel), 32'd256);
    run_slot("r1_ch4", 3'd4, 12'h456, t);
    run_slot("r1_ch5", 3'd5, 12'h789, t);
    run_slot("r1_ch6", 3'd6, 12'hABC, t);
    repeat (5) @(negedge clk);
    check("r1_lft", 32'(lft_ld), 32'h123);
    check("r1_rght", 32'(rght_ld), 32'h456);
    check("r1_steer", 32'(steer_pot), 32'h789);
    check("r1_batt", 32'(batt), 32'hABC);
    check("r1_vld_cnt", 32'(vld_cnt - v0), 32'd1);

    // Round 2: channel 5 never answers.
    v0 = vld_cnt;
    run_slot("r2_ch0", 3'd0, 12'h111, t);
    check("r2_period", 32'(t - t_first), 32'd256);
    run_slot("r2_ch4", 3'd4, 12'h222, t);
    wait_strt(600, ch, ts);
    check("r2_ch5", 32'(ch), 32'd5);
    seen_err = 1'b0;
    n_err    = 0;
    for (int i = 0; i < 1100 && !seen_err; i++) begin
      @(negedge clk);
      if (a2d_err) begin
        seen_err = 1'b1;
        n_err    = cyc - ts;
      end
    end
    check("r2_err_seen", 32'(seen_err), 32'd1);
    check("r2_err_delay", 32'(n_err >= 1024 && n_err <= 1025), 32'd1);
    run_slot("r2_ch6", 3'd6, 12'h333, t);
    repeat (5) @(negedge clk);
    check("r2_lft", 32'(lft_ld), 32'(L2));
    check("r2_rght", 32'(rght_ld), 32'(R2));
    check("r2_steer_kept", 32'(steer_pot), 32'h789);
    check("r2_batt", 32'(batt), 32'h333);
    check("r2_vld_cnt", 32'(vld_cnt - v0), 32'd1);
    check("r2_err_sticky", 32'(a2d_err), 32'd1);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    check("err_clr", 32'(a2d_err), 32'd0);

    // Round 3: done lands on the exact timeout cycle.
    run_slot("r3_ch0", 3'd0, 12'h0AA, t);
    run_slot("r3_ch4", 3'd4, 12'h0BB, t);
    wait_strt(600, ch, ts);
    check("r3_ch5", 32'(ch), 32'd5);
    respond(1024, 12'h0F0);
    run_slot("r3_ch6", 3'd6, 12'h0CC, t);
    repeat (5) @(negedge clk);
    check("r3_steer_edge", 32'(steer_pot), 32'h0F0);
    check("r3_err_edge", 32'(a2d_err), 32'd0);
    check("r3_lft", 32'(lft_ld), 32'(L3));
    check("r3_rght", 32'(rght_ld), 32'(R3));

    // Round 4: en drops while waiting on channel 4.
    v0 = vld_cnt;
    run_slot("r4_ch0", 3'd0, 12'h0DD, t);
    wait_strt(600, ch, ts);
    check("r4_ch4", 32'(ch), 32'd4);
    @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    #1;
    a2d_done = 1'b1;
    a2d_data = 12'h555;
    @(posedge clk);
    #1;
    a2d_done = 1'b0;
    a2d_data = 12'd0;
    s0 = strt_cnt;
    repeat (20) @(negedge clk);
    check("r4_no_strt", 32'(strt_cnt - s0), 32'd0);
    check("r4_no_vld", 32'(vld_cnt - v0), 32'd0);
    check("r4_lft", 32'(lft_ld), 32'(L4));
    check("r4_rght", 32'(rght_ld), 32'(R4));
    check("r4_steer", 32'(steer_pot), 32'h0F0);

    // Spurious done pulses while idle.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      a2d_done = 1'b1;
      a2d_data = 12'hFFF;
      @(posedge clk);
      #1;
      a2d_done = 1'b0;
      a2d_data = 12'd0;
    end
    repeat (3) @(negedge clk);
    check("idle_lft", 32'(lft_ld), 32'(L4));
    check("idle_rght", 32'(rght_ld), 32'(R4));
    check("idle_steer", 32'(steer_pot), 32'h0F0);
    check("idle_batt", 32'(batt), 32'h0CC);
    check("idle_no_strt", 32'(strt_cnt - s0), 32'd0);

    // Round 5: restart at slot 0 on a tick boundary, then reset mid-wait.
    @(posedge clk);
    #1 en = 1'b1;
    wait_strt(600, ch, t);
    check("r5_restart_ch0", 32'(ch), 32'd0);
    check("r5_tick_align", 32'((t - t_rel) % 256), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    t_rel = cyc;
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk);
    #1;
    a2d_done = 1'b1;
    a2d_data = 12'h7FF;
    @(posedge clk);
    #1;
    a2d_done = 1'b0;
    a2d_data = 12'd0;
    @(negedge clk);
    check("late_lft", 32'(lft_ld), 32'd0);
    check("late_err", 32'(a2d_err), 32'd0);

    // Rounds 6-7: lft 100 then 200 (averaged when enabled).
    run_slot("r6_ch0", 3'd0, 12'h100, t);
    check("r6_first_strt", 32'(t - t_rel), 32'd256);
    run_slot("r6_ch4", 3'd4, 12'h010, t);
    run_slot("r6_ch5", 3'd5, 12'h020, t);
    run_slot("r6_ch6", 3'd6, 12'h030, t);
    repeat (3) @(negedge clk);
    check("r6_lft", 32'(lft_ld), 32'h100);
    run_slot("r7_ch0", 3'd0, 12'h200, t);
    run_slot("r7_ch4", 3'd4, 12'h040, t);
    run_slot("r7_ch5", 3'd5, 12'h050, t);
    run_slot("r7_ch6", 3'd6, 12'h060, t);
    repeat (3) @(negedge clk);
    check("r7_lft", 32'(lft_ld), 32'(L7));
    check("r7_batt", 32'(batt), 32'h060);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/a2d_sched.md
Name: a2d_sched

Overview:
- Round-robin scheduler that shares the single SPI A2D interface among four analog sources: left load cell, right load cell, steering pot and battery.
- Sequences one conversion per source per round and holds the latest 12-bit results in registers.
- lft_ld/rght_ld feed the steering-enable logic; steer_pot/batt feed balance control and the battery monitor.
- Pulses smpl_vld when a full round completes and flags A2D timeouts.

Parameters:
FAST_SIM, 1, 1: round period 2^8 clk cycles; 0: round period 2^16 clk cycles (about 1.3 ms at 50 MHz)
TMO_CYC, 1024, max cycles to wait for a2d_done before declaring a timeout

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous active-high reset
en  in  1  scanning enable; rounds start only while high
err_clr  in  1  clears sticky a2d_err
a2d_done  in  1  one-cycle pulse from SPI A2D: conversion complete
a2d_data  in  12  conversion result, valid in the cycle a2d_done is high
a2d_strt  out  1  one-cycle pulse starting a conversion
a2d_chnl  out  3  A2D channel select, stable from a2d_strt through a2d_done/timeout
lft_ld  out  12  latest left load-cell result (channel 0)
rght_ld  out  12  latest right load-cell result (channel 4)
steer_pot  out  12  latest steering-pot result (channel 5)
batt  out  12  latest battery result (channel 6)
smpl_vld  out  1  one-cycle pulse after the last slot of each round
a2d_err  out  1  sticky: at least one conversion timed out

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high; rst is sampled only on the rising edge of clk.
- Reset values:
  - all result registers 0; a2d_strt 0; a2d_chnl 0; smpl_vld 0; a2d_err 0.
  - period timer 0; slot index 0; state IDLE.
- Period timer: free-running, width 8 (FAST_SIM=1) or 16 (FAST_SIM=0). It wraps to 0 after all-ones. "tick" is high in the cycle the timer equals all-ones.
- Slot order: 0 lft (ch 0), 1 rght (ch 4), 2 steer (ch 5), 3 batt (ch 6). Each round always restarts at slot 0.
- States:
  - IDLE: if tick && en, go to START with slot=0. Otherwise stay.
  - START: a2d_strt=1 for exactly one cycle; a2d_chnl = channel of current slot; clear timeout counter; go to WAIT.
  - WAIT: if a2d_done, latch a2d_data into the slot register on that edge and go to NEXT. Else if the timeout counter reaches TMO_CYC-1, set a2d_err, leave the slot register unchanged, and go to NEXT. Else increment the counter.
  - NEXT: if slot==3 or en==0, pulse smpl_vld (only when slot==3), reset slot to 0 and go to IDLE. Otherwise increment slot and go to START.
- Latency: the first a2d_strt occurs 1 cycle after tick. With an immediate A2D, a round takes 4×(START+WAIT+NEXT) plus the A2D conversion time.
- a2d_done and timeout in the same cycle: the data is accepted and a2d_err is not set.
- a2d_done outside WAIT is ignored: no register change, no state change.
- a tick arriving while a round is in progress is dropped; no queueing.
- en falling mid-round: the current conversion completes or times out, then the block returns to IDLE without smpl_vld. Registers already updated keep their values.
- err_clr clears a2d_err unless a timeout sets it in the same cycle; set wins.
- rst asserted mid-conversion: everything returns to reset values on the next edge; a late a2d_done is ignored.
- a2d_chnl holds its value in IDLE (last channel used, 0 after reset).

Optional Feature:
- Macro: A2D_SCHED_LD_AVG_EN.
- Defined:
  - lft_ld and rght_ld are 2-sample averages, new = (prev + sample) >> 1 using a 13-bit intermediate sum with truncation.
  - The first sample after reset loads directly, with no averaging against 0.
  - steer_pot and batt are unaffected.
- Not defined: all four registers load the raw a2d_data.

Test Plan:
- Reset then en=1, FAST_SIM=1, model returns 12'h123/12'h456/12'h789/12'hABC two cycles after each strt:
  - required channels in order 0,4,5,6;
  - required register values lft_ld=123, rght_ld=456, steer_pot=789, batt=ABC;
  - exactly one smpl_vld after the batt latch;
  - next round starts at a timer tick 256 cycles after the previous one.
- Model never answers channel 5:
  - steer_pot keeps its old value;
  - a2d_err rises 1024 cycles after that strt;
  - channel 6 still converts and smpl_vld still pulses.
  - Then err_clr=1 for 1 cycle drops a2d_err to 0.
- a2d_done on the exact timeout cycle with data 12'h0F0: register = 0F0, a2d_err stays 0.
- en dropped during channel 4 wait:
  - channel 4 completes and latches;
  - no strt for channel 5 and no smpl_vld;
  - state returns to IDLE.
- Spurious a2d_done pulses (data 12'hFFF) while in IDLE: all registers unchanged.
- rst asserted mid-wait, then a late a2d_done: all outputs 0 after the edge; late data not latched.
- With A2D_SCHED_LD_AVG_EN defined, lft samples 12'h100 then 12'h200: lft_ld = 100 then 180.
